// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle control sequencer for the small CPU.
// Fetches an instruction over the req/ready memory handshake, decodes it,
// and drives the register-file selects and write enables, the ALU op,
// data-memory accesses and the program counter.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   mem_req/we/addr/wdata    unified memory request (held until mem_ready)
//   mem_rdata, mem_ready     memory read data / request completion
//   rsel_a, rsel_b           register read selects (rd field, rs field)
//   rdata_a, rdata_b         register read data (combinational from selects)
//   alu_op, alu_result       ALU operation select / combinational result
//   reg_wen, reg_wdata       one-hot register write pulse and write data
//   flag_zero                zero flag from the last ALU op or LOAD
//   pc                       program counter
//   instr_done               one-cycle pulse when an instruction retires
module cpu_ctrl_seq #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int PC_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [PC_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic [DATA_W-1:0]            mem_rdata,
   input  logic                         mem_ready,
   output logic [$clog2(NUM_REGS)-1:0]  rsel_a,
   output logic [$clog2(NUM_REGS)-1:0]  rsel_b,
   input  logic [DATA_W-1:0]            rdata_a,
   input  logic [DATA_W-1:0]            rdata_b,
   output logic [1:0]                   alu_op,
   input  logic [DATA_W-1:0]            alu_result,
   output logic [NUM_REGS-1:0]          reg_wen,
   output logic [DATA_W-1:0]            reg_wdata,
   output logic                         flag_zero,
   output logic [PC_W-1:0]              pc,
   output logic                         instr_done
);

   localparam int REG_SEL_W = $clog2(NUM_REGS);
   localparam int IMM_W     = DATA_W - 3 - REG_SEL_W;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_XOR   = 3'b001;
   localparam logic [2:0] OP_OR    = 3'b010;
   localparam logic [2:0] OP_AND   = 3'b011;
   localparam logic [2:0] OP_SAVE  = 3'b100;
   localparam logic [2:0] OP_LOAD  = 3'b101;
   localparam logic [2:0] OP_STORE = 3'b110;
   localparam logic [2:0] OP_JUMP  = 3'b111;

   logic [2:0]           r_state;
   logic [DATA_W-1:0]    r_ir;
   logic [PC_W-1:0]      r_pc;
   logic                 r_flag_zero;
   logic [NUM_REGS-1:0]  r_reg_wen;
   logic [DATA_W-1:0]    r_reg_wdata;
   logic                 r_done;
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [PC_W-1:0]      r_mem_addr;
   logic [DATA_W-1:0]    r_mem_wdata;
   logic [REG_SEL_W-1:0] r_rsel_a;
   logic [REG_SEL_W-1:0] r_rsel_b;
   logic [1:0]           r_alu_op;

   logic [2:0]           w_op;
   logic [REG_SEL_W-1:0] w_rd;
   logic [IMM_W-1:0]     w_imm;
   logic                 w_jump_taken;
   logic                 w_store_done;

   // One-hot write enable for a register select.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
      onehot = NUM_REGS'(1) << sel;
   endfunction

   assign w_op         = r_ir[DATA_W-1 -: 3];
   assign w_rd         = r_ir[DATA_W-4 -: REG_SEL_W];
   assign w_imm        = r_ir[IMM_W-1:0];
   assign w_jump_taken = (w_op == OP_JUMP) && (!w_imm[0] || r_flag_zero);
   // A STORE retires in the same cycle its memory write is accepted.
   assign w_store_done = (r_state == S_MEM) && r_mem_req && r_mem_we && mem_ready;

   // Sequencer state, datapath registers and registered control outputs.
   // Outputs are loaded on the edge that enters the state using them, so
   // each state sees its controls from its first cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_ir        <= '0;
         r_pc        <= '0;
         r_flag_zero <= 1'b0;
         r_reg_wen   <= '0;
         r_reg_wdata <= '0;
         r_done      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rsel_a    <= '0;
         r_rsel_b    <= '0;
         r_alu_op    <= 2'b00;
      end else begin
         r_reg_wen <= '0;
         r_done    <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (!r_mem_req) begin
                  // first cycle after reset: open the fetch request
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc;
               end else if (mem_ready) begin
                  // selects and ALU op come straight from the fetched word so
                  // rdata_*/alu_result are already valid during DECODE
                  r_ir      <= mem_rdata;
                  r_pc      <= r_pc + PC_W'(1);
                  r_mem_req <= 1'b0;
                  r_rsel_a  <= mem_rdata[DATA_W-4 -: REG_SEL_W];
                  r_rsel_b  <= mem_rdata[REG_SEL_W-1:0];
                  r_alu_op  <= mem_rdata[DATA_W-2 -: 2];
                  r_state   <= S_DECODE;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
               case (w_op)
                  OP_ADD, OP_XOR, OP_OR, OP_AND: begin
                     r_reg_wen   <= onehot(w_rd);
                     r_reg_wdata <= alu_result;
                     r_done      <= 1'b1;
                  end
                  OP_SAVE: begin
                     r_reg_wen   <= onehot(w_rd);
                     r_reg_wdata <= DATA_W'(w_imm);
                     r_done      <= 1'b1;
                  end
                  OP_JUMP:  r_done <= 1'b1;
                  default:  r_done <= 1'b0;
               endcase
            end
            S_EXEC: begin
               case (w_op)
                  OP_LOAD, OP_STORE: begin
                     r_state     <= S_MEM;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= (w_op == OP_STORE);
                     r_mem_addr  <= PC_W'(rdata_b);
                     r_mem_wdata <= rdata_a;
                  end
                  default: begin
                     // ALU ops update the flag; SAVE and JUMP leave it alone
                     if (!w_op[2]) begin
                        r_flag_zero <= (r_reg_wdata == '0);
                     end else begin
                        r_flag_zero <= r_flag_zero;
                     end
                     r_state   <= S_FETCH;
                     r_mem_req <= 1'b1;
                     r_mem_we  <= 1'b0;
                     if (w_jump_taken) begin
                        r_pc       <= PC_W'(rdata_a);
                        r_mem_addr <= PC_W'(rdata_a);
                     end else begin
                        r_mem_addr <= r_pc;
                     end
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (r_mem_we) begin
                     // STORE retires now; next fetch starts immediately
                     r_state    <= S_FETCH;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= r_pc;
                  end else begin
                     r_state     <= S_WB;
                     r_mem_req   <= 1'b0;
                     r_reg_wen   <= onehot(w_rd);
                     r_reg_wdata <= mem_rdata;
                     r_done      <= 1'b1;
                  end
               end else begin
                  r_state <= S_MEM;
               end
            end
            S_WB: begin
               r_flag_zero <= (r_reg_wdata == '0);
               r_state     <= S_FETCH;
               r_mem_req   <= 1'b1;
               r_mem_we    <= 1'b0;
               r_mem_addr  <= r_pc;
            end
            default: begin
               r_state   <= S_FETCH;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign rsel_a     = r_rsel_a;
   assign rsel_b     = r_rsel_b;
   assign alu_op     = r_alu_op;
   assign reg_wen    = r_reg_wen;
   assign reg_wdata  = r_reg_wdata;
   assign flag_zero  = r_flag_zero;
   assign pc         = r_pc;
   assign instr_done = r_done | w_store_done;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed testbench for cpu_ctrl_seq (default parameters 8/4/8).
// Inputs are driven just after the falling edge; outputs are sampled one
// time unit later, well away from the rising edge.
module tb_cpu_ctrl_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_req, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_ready;
   logic [1:0] rsel_a, rsel_b;
   logic [7:0] rdata_a, rdata_b;
   logic [1:0] alu_op;
   logic [7:0] alu_result;
   logic [3:0] reg_wen;
   logic [7:0] reg_wdata;
   logic       flag_zero;
   logic [7:0] pc;
   logic       instr_done;

   int n_total = 0;
   int n_pass  = 0;

   cpu_ctrl_seq dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .rsel_a(rsel_a), .rsel_b(rsel_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .alu_op(alu_op), .alu_result(alu_result),
      .reg_wen(reg_wen), .reg_wdata(reg_wdata),
      .flag_zero(flag_zero), .pc(pc), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   // advance to the next cycle's drive point
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", mem_req); else n_pass++;
      n_total++; if (reg_wen !== 4'b0000 || instr_done !== 1'b0) $display("FAIL rst_wen got %b/%b exp 0000/0", reg_wen, instr_done); else n_pass++;
      rst_n = 1'b1;
      step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) $display("FAIL rst_first_req got %b/%h exp 1/00", mem_req, mem_addr); else n_pass++;
      // reset in the middle of an open fetch request
      rst_n = 1'b0;
      #1;
      n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mid_req got %b exp 0", mem_req); else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || pc !== 8'h00 || flag_zero !== 1'b0)
         $display("FAIL rst_release got req=%b addr=%h pc=%h z=%b exp 1/00/00/0", mem_req, mem_addr, pc, flag_zero); else n_pass++;
   endtask

   // SAVE r1,#5 at address 0
   task automatic test_save();
      mem_rdata = 8'b100_01_101; mem_ready = 1'b1; #1;
      step(); mem_ready = 1'b0; #1;
      n_total++; if (mem_req !== 1'b0 || pc !== 8'h01) $display("FAIL save_decode got req=%b pc=%h exp 0/01", mem_req, pc); else n_pass++;
      n_total++; if (rsel_a !== 2'd1 || rsel_b !== 2'd1) $display("FAIL save_rsel got %0d/%0d exp 1/1", rsel_a, rsel_b); else n_pass++;
      step();
      n_total++; if (reg_wen !== 4'b0010 || reg_wdata !== 8'h05 || instr_done !== 1'b1)
         $display("FAIL save_exec got wen=%b wd=%h done=%b exp 0010/05/1", reg_wen, reg_wdata, instr_done); else n_pass++;
      step();
      n_total++; if (reg_wen !== 4'b0000 || instr_done !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h01)
         $display("FAIL save_next got wen=%b done=%b req=%b addr=%h exp 0000/0/1/01", reg_wen, instr_done, mem_req, mem_addr); else n_pass++;
   endtask

   // XOR r2,r2 (result 0) then AND r0,r1 (result 03)
   task automatic test_alu();
      mem_rdata = 8'b001_10_010; mem_ready = 1'b1; alu_result = 8'h00; #1;
      step(); mem_ready = 1'b0; #1;
      n_total++; if (alu_op !== 2'b01 || rsel_a !== 2'd2 || rsel_b !== 2'd2) $display("FAIL xor_decode got op=%b a=%0d b=%0d exp 01/2/2", alu_op, rsel_a, rsel_b); else n_pass++;
      step();
      n_total++; if (reg_wen !== 4'b0100 || reg_wdata !== 8'h00 || instr_done !== 1'b1)
         $display("FAIL xor_exec got wen=%b wd=%h done=%b exp 0100/00/1", reg_wen, reg_wdata, instr_done); else n_pass++;
      step();
      n_total++; if (flag_zero !== 1'b1 || mem_addr !== 8'h02) $display("FAIL xor_flag got z=%b addr=%h exp 1/02", flag_zero, mem_addr); else n_pass++;
      mem_rdata = 8'b011_00_001; mem_ready = 1'b1; alu_result = 8'h03; #1;
      step(); mem_ready = 1'b0; #1;
      n_total++; if (alu_op !== 2'b11) $display("FAIL and_op got %b exp 11", alu_op); else n_pass++;
      step();
      n_total++; if (reg_wen !== 4'b0001 || reg_wdata !== 8'h03) $display("FAIL and_exec got wen=%b wd=%h exp 0001/03", reg_wen, reg_wdata); else n_pass++;
      step();
      n_total++; if (flag_zero !== 1'b0 || pc !== 8'h03) $display("FAIL and_flag got z=%b pc=%h exp 0/03", flag_zero, pc); else n_pass++;
   endtask

   // LOAD r3,[r1] with two wait states
   task automatic test_load();
      mem_rdata = 8'b101_11_001; mem_ready = 1'b1; rdata_b = 8'h40; #1;
      n_total++; if (mem_addr !== 8'h03) $display("FAIL load_fetch_addr got %h exp 03", mem_addr); else n_pass++;
      step(); mem_ready = 1'b0; #1;
      step();
      n_total++; if (instr_done !== 1'b0 || reg_wen !== 4'b0000) $display("FAIL load_exec got done=%b wen=%b exp 0/0000", instr_done, reg_wen); else n_pass++;
      for (int w = 0; w < 3; w++) begin
         step();
         if (w == 2) begin mem_ready = 1'b1; mem_rdata = 8'h5A; end
         #1;
         n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h40 || instr_done !== 1'b0)
            $display("FAIL load_mem%0d got req=%b we=%b addr=%h done=%b exp 1/0/40/0", w, mem_req, mem_we, mem_addr, instr_done); else n_pass++;
      end
      step(); mem_ready = 1'b0; mem_rdata = 8'h00; #1;
      n_total++; if (reg_wen !== 4'b1000 || reg_wdata !== 8'h5A || instr_done !== 1'b1 || mem_req !== 1'b0)
         $display("FAIL load_wb got wen=%b wd=%h done=%b req=%b exp 1000/5a/1/0", reg_wen, reg_wdata, instr_done, mem_req); else n_pass++;
      step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 8'h04 || flag_zero !== 1'b0 || reg_wen !== 4'b0000)
         $display("FAIL load_next got req=%b addr=%h z=%b wen=%b exp 1/04/0/0000", mem_req, mem_addr, flag_zero, reg_wen); else n_pass++;
   endtask

   // STORE r0,[r2], zero-wait
   task automatic test_store();
      mem_rdata = 8'b110_00_010; mem_ready = 1'b1; rdata_a = 8'hAA; rdata_b = 8'h10; #1;
      step(); mem_ready = 1'b0; #1;
      step();
      n_total++; if (instr_done !== 1'b0) $display("FAIL store_exec got done=%b exp 0", instr_done); else n_pass++;
      step(); mem_ready = 1'b1; #1;
      n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hAA)
         $display("FAIL store_mem got req=%b we=%b addr=%h wd=%h exp 1/1/10/aa", mem_req, mem_we, mem_addr, mem_wdata); else n_pass++;
      n_total++; if (instr_done !== 1'b1 || reg_wen !== 4'b0000) $display("FAIL store_done got done=%b wen=%b exp 1/0000", instr_done, reg_wen); else n_pass++;
      step(); mem_ready = 1'b0; #1;
      n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h05 || instr_done !== 1'b0)
         $display("FAIL store_next got req=%b we=%b addr=%h done=%b exp 1/0/05/0", mem_req, mem_we, mem_addr, instr_done); else n_pass++;
   endtask

   // conditional JUMP not taken, then taken to FF, then pc wrap
   task automatic test_jump();
      mem_rdata = 8'b111_01_001; mem_ready = 1'b1; rdata_a = 8'h77; #1;
      step(); mem_ready = 1'b0; #1;
      step();
      n_total++; if (instr_done !== 1'b1 || reg_wen !== 4'b0000) $display("FAIL jnt_exec got done=%b wen=%b exp 1/0000", instr_done, reg_wen); else n_pass++;
      step();
      n_total++; if (mem_addr !== 8'h06 || pc !== 8'h06) $display("FAIL jnt_pc got addr=%h pc=%h exp 06/06", mem_addr, pc); else n_pass++;
      // XOR to set the zero flag
      mem_rdata = 8'b001_10_010; mem_ready = 1'b1; alu_result = 8'h00; #1;
      step(); mem_ready = 1'b0; #1;
      step(); step();
      n_total++; if (flag_zero !== 1'b1 || mem_addr !== 8'h07) $display("FAIL jt_setz got z=%b addr=%h exp 1/07", flag_zero, mem_addr); else n_pass++;
      mem_rdata = 8'b111_01_001; mem_ready = 1'b1; rdata_a = 8'hFF; #1;
      step(); mem_ready = 1'b0; #1;
      step();
      n_total++; if (instr_done !== 1'b1) $display("FAIL jt_exec got done=%b exp 1", instr_done); else n_pass++;
      step();
      n_total++; if (mem_addr !== 8'hFF || pc !== 8'hFF || mem_req !== 1'b1 || flag_zero !== 1'b1)
         $display("FAIL jt_target got addr=%h pc=%h req=%b z=%b exp ff/ff/1/1", mem_addr, pc, mem_req, flag_zero); else n_pass++;
      mem_rdata = 8'b100_00_000; mem_ready = 1'b1; #1;
      step(); mem_ready = 1'b0; #1;
      n_total++; if (pc !== 8'h00) $display("FAIL pc_wrap got %h exp 00", pc); else n_pass++;
      step();
      n_total++; if (reg_wen !== 4'b0001 || reg_wdata !== 8'h00 || flag_zero !== 1'b1)
         $display("FAIL wrap_save got wen=%b wd=%h z=%b exp 0001/00/1", reg_wen, reg_wdata, flag_zero); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b0;
      rdata_a = 8'h00; rdata_b = 8'h00; alu_result = 8'h00;
      test_reset();
      test_save();
      test_alu();
      test_load();
      test_store();
      test_jump();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
